// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin conditioning, clock filter, frame FSM
// and inter-edge timeout. Emits one-cycle byte/error strobes.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       timeout_err
);

    localparam int unsigned TO_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned FW        = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW        = $clog2(TO_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall_q;
    logic          dat_q;
    logic [TW-1:0] to_cnt;
    logic          to_expire_c;

    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          byte_valid_d, parity_err_d, timeout_err_d;

    // Synchronizers plus a level filter; DAT is captured with the accepted fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall_q   <= 1'b0;
            dat_q    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            fall_q   <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall_q   <= ~clk_sync[1];
                dat_q    <= dat_sync[1];
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign to_expire_c = (state_q != IDLE) && !fall_q && (to_cnt == TW'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (fall_q || state_q == IDLE || to_expire_c) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            byte_valid  <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            byte_valid  <= byte_valid_d;
            parity_err  <= parity_err_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        byte_valid_d  = 1'b0;
        parity_err_d  = 1'b0;
        timeout_err_d = 1'b0;
        if (to_expire_c) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
        end else if (fall_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_q;
                    state_d = STOP;
                end
                STOP: begin
                    // Odd parity: data bits plus parity bit must hold an odd count of ones.
                    if (dat_q && ((^shift_q) ^ par_q)) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: Set-2 E0/F0 prefix decoding into key events, buffered
// in a show-ahead FIFO with a valid/ready consumer handshake.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_US  = 2000
) (
    input  logic                               CLOCK_50,
    input  logic                               reset_n,
    input  logic                               PS2_CLK,
    input  logic                               PS2_DAT,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic [7:0]                         ev_code,
    output logic                               ev_break,
    output logic                               ev_extended,
    output logic                               parity_err,
    output logic                               timeout_err,
    output logic                               overflow,
    input  logic                               ovf_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        ext_q, brk_q;
    logic        push_c, pop_c, full_c, wr_c, drop_c;
    ps2_event_t  push_ev_c;
    ps2_event_t  head_c;
    ps2_event_t  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_d;

    ps2_frame_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_US  (TIMEOUT_US)
    ) u_frame_rx (
        .clk         (CLOCK_50),
        .rst_n       (reset_n),
        .ps2_clk     (PS2_CLK),
        .ps2_dat     (PS2_DAT),
        .byte_data   (rx_byte),
        .byte_valid  (rx_valid),
        .parity_err  (parity_err),
        .timeout_err (timeout_err)
    );

    assign push_c    = rx_valid && (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);
    assign push_ev_c = '{extended: ext_q, brk: brk_q, code: rx_byte};

    // Prefix flags; any bad or abandoned frame discards a pending prefix.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (parity_err || timeout_err) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_q <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    assign full_c  = (count_q == CW'(FIFO_DEPTH));
    assign pop_c   = ev_valid && ev_ready;
    assign wr_c    = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;
    assign count_d = count_q + CW'(wr_c) - CW'(pop_c);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            ev_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= push_ev_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q  <= count_d;
            ev_valid <= (count_d != '0);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head_c      = mem[rd_ptr];
    assign ev_code     = head_c.code;
    assign ev_break    = head_c.brk;
    assign ev_extended = head_c.extended;
    assign fifo_count  = count_q;

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Parametrised successor to the keyboard press driver. Receives PS/2 device-to-host frames and checks start, odd-parity and stop bits. Decodes Set-2 E0/F0 prefixes into single key events carrying make/break and extended flags, and buffers the events in a FIFO with a valid/ready output handshake. Sits between the board-level PS2_CLK/PS2_DAT pins and game logic; the top level ties the inout pins to this block's inputs, since the block is receive-only.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; used to size the timeout.
FIFO_DEPTH, 8, number of buffered key events (power of two, >= 2).
FILTER_LEN, 8, consecutive equal samples required before a PS2_CLK level change is accepted.
TIMEOUT_US, 2000, maximum gap between PS2_CLK falling edges inside a frame.

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
PS2_CLK  input  1  raw PS/2 clock pin, asynchronous.
PS2_DAT  input  1  raw PS/2 data pin, asynchronous.
ev_valid  output  1  FIFO head holds an event.
ev_ready  input  1  consumer accepts the head event when high with ev_valid.
ev_code  output  8  scan code of the head event.
ev_break  output  1  1 = key release (F0 seen), 0 = press.
ev_extended  output  1  1 = E0-prefixed code.
parity_err  output  1  one-cycle pulse on a frame with bad parity or bad start/stop bit.
timeout_err  output  1  one-cycle pulse when a partial frame is abandoned.
overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
ovf_clr  input  1  synchronous clear of overflow.
fifo_count  output  $clog2(FIFO_DEPTH+1)  events currently buffered.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FIFO empty, both FSMs in their idle state, prefix flags cleared, filtered clock = 1.
- Input conditioning: 2-flop synchronizer on both pins. Filtered PS2_CLK changes only after FILTER_LEN identical synchronized samples. A filtered 1->0 transition is a "fall" strobe; PS2_DAT is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with DAT=0 -> DATA with bit count 0; fall with DAT=1 -> stay (spurious).
  - DATA: shift 8 bits, LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on fall, the frame is good if DAT=1 and the XOR of 8 data bits and parity = 1. Good frame -> byte strobe. Otherwise parity_err pulse and no byte. Either way -> IDLE.
- Timeout: counter = CLK_FREQ_HZ/1000000*TIMEOUT_US cycles. It is cleared on every fall and runs only outside IDLE. On expiry: timeout_err pulse, FSM -> IDLE, partial byte discarded.
- Decoder, on each byte strobe:
  - 8'hE0 sets ext.
  - 8'hF0 sets brk.
  - Any other byte pushes event {ext, brk, byte} and clears ext and brk.
  - parity_err or timeout_err also clears ext and brk.
  - 8'hE1 and other bytes receive no special treatment.
- Latency: push occurs the cycle after the stop-bit fall is detected. ev_valid rises the following cycle. FIFO is show-ahead: head fields are valid whenever ev_valid=1.
- FIFO:
  - Pop when ev_valid & ev_ready.
  - Push while full and no pop: event dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty is ignored.
- overflow: ovf_clr wins over a simultaneous set only if no drop occurs in that cycle; a drop in that cycle keeps overflow = 1.

Decomposition:
- Package ps2_pkg holds:
  - localparams PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - typedef struct packed {logic extended; logic brk; logic [7:0] code;} ps2_event_t;
  - enum frame_state_t {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_frame_rx contains the synchronizer, filter, frame FSM and timeout, and outputs byte/strobe/error pulses.
- Decoder and FIFO stay in the top block.

Test Plan:
- Frame 0x1C with parity 0, stop 1, ev_ready=1 -> one event: code=0x1C, break=0, extended=0; fifo_count returns to 0.
- Bytes F0,1C -> single event: code=0x1C, break=1. Bytes E0,F0,74 -> code=0x74, break=1, extended=1. No events are produced for the prefix bytes.
- Frame 0x1C with parity bit 1 -> parity_err pulses once, no event. A following E0 then a bad-parity frame then 0x74 -> event has extended=0.
- ev_ready=0, send 9 make codes 0x16..0x1E -> fifo_count=8, overflow=1. Draining returns 0x16..0x1D in order; ovf_clr then clears overflow.
- Send start bit plus 4 data bits, then hold PS2_CLK high for 3 ms -> timeout_err pulses once. A subsequent 0x1C frame decodes correctly.
- Assert reset_n=0 mid-frame and with 3 events buffered -> all outputs 0 immediately, FIFO empty. The next full frame decodes correctly.
